// File: rtl/cnu_minsum_serial.sv
// Serial min-sum check node unit: collects DC edge messages, then emits DC extrinsic messages.
// Define OFFSET_MINSUM_EN for offset min-sum (emitted magnitude reduced by OFFSET, floored at 0).
module cnu_minsum_serial #(
    parameter int unsigned DC     = 6,
    parameter int unsigned OFFSET = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_data,
    output logic       out_last,
    output logic       parity_ok,
    output logic       syndrome_valid
);
    localparam int unsigned CntW = (DC > 1) ? $clog2(DC) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(DC - 1);

    typedef enum logic {StAccum, StEmit} state_t;
    state_t state_q, state_d;

    logic [CntW-1:0] in_cnt_q, out_cnt_q, min_idx_q, b_idx_q;
    logic [3:0]      min1_q, min2_q, b_min1_q, b_min2_q;
    logic            sign_acc_q, hd_acc_q, b_sign_q;
    logic [DC-1:0]   sign_q;
    logic            out_valid_q, out_last_q, parity_q, syn_q;
    logic [4:0]      out_data_q;

    logic [3:0]      in_mag;
    logic            in_sign, in_hd;
    logic            accept, fire, last_in, last_out;
    logic [3:0]      nx_min1, nx_min2;
    logic [CntW-1:0] nx_idx, nj;
    logic            nx_sign_acc;
    logic [4:0]      first_data, next_data;

    function automatic logic [3:0] emit_mag(input logic [3:0] m);
`ifdef OFFSET_MINSUM_EN
        emit_mag = (int'(m) > int'(OFFSET)) ? m - 4'(OFFSET) : 4'd0;
`else
        emit_mag = m;
`endif
    endfunction

`ifndef OFFSET_MINSUM_EN
    logic unused_offset;
    assign unused_offset = ^OFFSET;
`endif

    always_comb begin
        in_mag      = in_data[3:0];
        in_sign     = in_data[4];
        in_hd       = in_data[5];
        accept      = en && (state_q == StAccum) && in_valid;
        fire        = en && out_valid_q && out_ready;
        last_in     = accept && (in_cnt_q == LastIdx);
        last_out    = fire && (out_cnt_q == LastIdx);

        // Ties with min1 fall through to min2 so min_idx keeps the first occurrence.
        nx_min1 = min1_q;
        nx_min2 = min2_q;
        nx_idx  = min_idx_q;
        if (in_mag < min1_q) begin
            nx_min2 = min1_q;
            nx_min1 = in_mag;
            nx_idx  = in_cnt_q;
        end else if (in_mag < min2_q) begin
            nx_min2 = in_mag;
        end
        nx_sign_acc = sign_acc_q ^ in_sign;

        // Edge 0 is formed from the final accumulator values; sign_q[0] is already stored.
        first_data = {nx_sign_acc ^ sign_q[0], emit_mag((nx_idx == '0) ? nx_min2 : nx_min1)};
        nj         = out_cnt_q + CntW'(1);
        next_data  = {b_sign_q ^ sign_q[nj], emit_mag((nj == b_idx_q) ? b_min2_q : b_min1_q)};

        state_d = state_q;
        if (last_in) begin
            state_d = StEmit;
        end else if (last_out) begin
            state_d = StAccum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            min_idx_q   <= '0;
            b_idx_q     <= '0;
            min1_q      <= 4'd15;
            min2_q      <= 4'd15;
            b_min1_q    <= 4'd15;
            b_min2_q    <= 4'd15;
            sign_acc_q  <= 1'b0;
            hd_acc_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            sign_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            parity_q    <= 1'b0;
            syn_q       <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            syn_q   <= last_in;
            if (accept) begin
                sign_q[in_cnt_q] <= in_sign;
                sign_acc_q       <= nx_sign_acc;
                hd_acc_q         <= hd_acc_q ^ in_hd;
                min1_q           <= nx_min1;
                min2_q           <= nx_min2;
                min_idx_q        <= nx_idx;
                if (last_in) begin
                    in_cnt_q    <= '0;
                    parity_q    <= ~(hd_acc_q ^ in_hd);
                    b_min1_q    <= nx_min1;
                    b_min2_q    <= nx_min2;
                    b_idx_q     <= nx_idx;
                    b_sign_q    <= nx_sign_acc;
                    out_valid_q <= 1'b1;
                    out_data_q  <= first_data;
                    out_last_q  <= 1'b0;
                end else begin
                    in_cnt_q <= in_cnt_q + CntW'(1);
                end
            end
            if (fire) begin
                if (last_out) begin
                    out_cnt_q   <= '0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    min1_q      <= 4'd15;
                    min2_q      <= 4'd15;
                    min_idx_q   <= '0;
                    sign_acc_q  <= 1'b0;
                    hd_acc_q    <= 1'b0;
                end else begin
                    out_cnt_q  <= nj;
                    out_data_q <= next_data;
                    out_last_q <= (nj == LastIdx);
                end
            end
        end
    end

    assign in_ready       = en && (state_q == StAccum);
    assign out_valid      = en && out_valid_q;
    assign out_data       = out_data_q;
    assign out_last       = out_last_q;
    assign parity_ok      = parity_q;
    assign syndrome_valid = en && syn_q;

endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Randomized bench for cnu_minsum_serial against an extrinsic min/sign reference model.
module tb_cnu_minsum_serial;
    localparam int DC = 6;

    logic       clk = 1'b0;
    logic       rst, en, in_valid, in_ready, out_valid, out_ready, out_last;
    logic       parity_ok, syndrome_valid;
    logic [5:0] in_data;
    logic [4:0] out_data;

    int checks = 0, errors = 0;
    int cycle = 0, en_off_until = 0, ready_off_until = 0, syn_count = 0;
    bit rand_en = 0, rand_ready = 0;

    typedef struct {
        logic [4:0] data;
        logic       last;
    } exp_t;
    exp_t       expq[$];
    logic [5:0] frame[$];
    logic [4:0] got[$];
    bit         syn_pend = 0;
    logic       exp_par = 1'b0;

    cnu_minsum_serial #(.DC(DC), .OFFSET(1)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .parity_ok(parity_ok), .syndrome_valid(syndrome_valid)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cycle++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Extrinsic message for edge i: min and sign-XOR over every other edge of the frame.
    function automatic void model_frame();
        logic p;
        p = 1'b0;
        for (int i = 0; i < DC; i++) begin
            int   m;
            logic s;
            exp_t e;
            m = 16;
            s = 1'b0;
            for (int j = 0; j < DC; j++) begin
                if (j != i) begin
                    if (int'(frame[j][3:0]) < m) m = int'(frame[j][3:0]);
                    s ^= frame[j][4];
                end
            end
`ifdef OFFSET_MINSUM_EN
            m = (m > 1) ? m - 1 : 0;
`endif
            e.data = {s, 4'(m)};
            e.last = (i == DC - 1);
            expq.push_back(e);
            p ^= frame[i][5];
        end
        exp_par  = ~p;
        syn_pend = 1;
        frame.delete();
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            frame.delete();
            expq.delete();
            syn_pend = 0;
            exp_par  = 1'b0;
        end else begin
            chk("in_ready", 8'(in_ready), 8'(en && expq.size() == 0));
            chk("out_valid", 8'(out_valid), 8'(en && expq.size() != 0));
            if (en && syn_pend) begin
                chk("syndrome_pulse", 8'(syndrome_valid), 8'd1);
                syn_pend = 0;
            end else begin
                chk("syndrome_idle", 8'(syndrome_valid), 8'd0);
            end
            if (syndrome_valid) syn_count++;
            chk("parity_ok", 8'(parity_ok), 8'(exp_par));
            if (out_valid && expq.size() != 0) begin
                chk("out_data", 8'(out_data), 8'(expq[0].data));
                chk("out_last", 8'(out_last), 8'(expq[0].last));
                if (out_ready) begin
                    got.push_back(out_data);
                    void'(expq.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                frame.push_back(in_data);
                if (frame.size() == DC) model_frame();
            end
        end
    end

    // en/out_ready driven late in the cycle so the main flow can schedule drops at posedge+1.
    initial begin
        en = 1'b1;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            en = (cycle < en_off_until) ? 1'b0 : (rand_en ? ($urandom_range(7) != 0) : 1'b1);
            out_ready = (cycle < ready_off_until) ? 1'b0
                      : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
        end
    end

    task automatic send_item(input logic [5:0] d, input int gap);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL input_accept: got no acceptance, expected one within 300 cycles");
        end
    endtask

    task automatic send_frame(input int m[DC], input int s[DC], input int h[DC], input int gmax);
        for (int k = 0; k < DC; k++)
            send_item({1'(h[k]), 1'(s[k]), 4'(m[k])}, (gmax > 0) ? $urandom_range(gmax) : 0);
    endtask

    task automatic wait_outputs(input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 500) begin @(posedge clk); #1; k++; end
        if (got.size() < n) begin
            checks++;
            errors++;
            $display("FAIL output_wait: got %0d outputs, expected %0d", got.size(), n);
        end
    endtask

    task automatic chk_got(input string name, input int lit[DC]);
        for (int i = 0; i < DC; i++)
            chk(name, (i < got.size()) ? 8'(got[i]) : 8'hff, 8'(lit[i]));
    endtask

    initial begin
        int m[DC], s[DC], h[DC], z[DC], lit[DC];
        int syn0, k;
        z = '{0, 0, 0, 0, 0, 0};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 8'(out_valid), 8'd0);
        chk("reset_in_ready", 8'(in_ready), 8'd1);
        chk("reset_parity", 8'(parity_ok), 8'd0);
        @(posedge clk);
        #1;

        // Basic frame with a 5-cycle stall while edge 2 is presented.
        got.delete();
        syn0 = syn_count;
        m = '{5, 3, 7, 3, 9, 2};
        s = '{1, 0, 0, 1, 0, 0};
        h = '{0, 0, 1, 0, 0, 0};
        send_frame(m, s, h, 0);
        wait_outputs(2);
        ready_off_until = cycle + 5;
        repeat (4) begin @(posedge clk); #1; end
        chk("stall_hold", 8'(got.size()), 8'd2);
        wait_outputs(DC);
`ifdef OFFSET_MINSUM_EN
        lit = '{'h11, 'h01, 'h01, 'h11, 'h01, 'h02};
`else
        lit = '{'h12, 'h02, 'h02, 'h12, 'h02, 'h03};
`endif
        chk_got("basic_data", lit);
        chk("basic_parity", 8'(parity_ok), 8'd0);
        chk("basic_syn_count", 8'(syn_count - syn0), 8'd1);

        // Ties, with input gaps.
        got.delete();
        m = '{4, 4, 4, 4, 4, 4};
        s = '{1, 1, 1, 1, 1, 0};
        send_frame(m, s, z, 2);
        wait_outputs(DC);
`ifdef OFFSET_MINSUM_EN
        lit = '{'h03, 'h03, 'h03, 'h03, 'h03, 'h13};
`else
        lit = '{'h04, 'h04, 'h04, 'h04, 'h04, 'h14};
`endif
        chk_got("ties_data", lit);
        chk("ties_parity", 8'(parity_ok), 8'd1);

        // Enable dropped for 3 cycles mid-accumulation.
        got.delete();
        send_item(6'h06, 0);
        send_item(6'h32, 0);
        send_item(6'h19, 0);
        en_off_until = cycle + 3;
        @(negedge clk);
        chk("en_low_in_ready", 8'(in_ready), 8'd0);
        @(posedge clk);
        #1;
        send_item(6'h02, 0);
        send_item(6'h04, 0);
        send_item(6'h1b, 0);
        wait_outputs(DC);

        // Reset after 3 inputs; the following frame must not see the small stale minima.
        got.delete();
        send_item(6'h00, 0);
        send_item(6'h01, 0);
        send_item(6'h00, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m = '{8, 9, 10, 11, 12, 13};
        send_frame(m, z, z, 0);
        wait_outputs(DC);
`ifdef OFFSET_MINSUM_EN
        lit = '{'h08, 'h07, 'h07, 'h07, 'h07, 'h07};
`else
        lit = '{'h09, 'h08, 'h08, 'h08, 'h08, 'h08};
`endif
        chk_got("post_reset_data", lit);

        // Zero magnitudes (exercise offset clamp when enabled).
        got.delete();
        m = '{0, 5, 1, 3, 0, 7};
        s = '{0, 1, 0, 1, 1, 0};
        send_frame(m, s, z, 1);
        wait_outputs(DC);

        // Randomized frames with random enable drops, input gaps and output backpressure.
        rand_en = 1;
        rand_ready = 1;
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < DC; j++) begin
                logic [5:0] d;
                d = 6'($urandom);
                if (f % 2 == 1) d[3:0] = 4'($urandom_range(3));
                send_item(d, ($urandom_range(3) == 0) ? int'($urandom_range(2)) + 1 : 0);
            end
        end
        k = 0;
        while ((expq.size() != 0 || frame.size() != 0) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending outputs, expected 0", expq.size());
        end
        rand_en = 0;
        rand_ready = 0;
        repeat (3) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnu_minsum_serial.md
Name: cnu_minsum_serial

Overview:
- Serial min-sum Check Node Unit that consumes the 6-bit variable-to-check messages produced by the VNU and produces the 5-bit sign-magnitude check-to-variable messages the VNU takes as its X inputs.
- Operates one edge per cycle. It collects DC messages for one check node (ACCUM phase), then emits DC extrinsic messages (EMIT phase).
- Also reports the parity-check result computed from the VNU hard-decision bits.

Parameters:
- DC, 6, check-node degree (edges per frame); legal range 2..16.
- OFFSET, 1, magnitude offset used only when OFFSET_MINSUM_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  global enable; when 0, all state holds
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data
- in_data  input  6  VNU message {hd, sign, mag[3:0]}
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  5  {sign, mag[3:0]} message to VNU X input
- out_last  output  1  high with the final edge (DC-1) of a frame
- parity_ok  output  1  1 = XOR of the frame's hd bits is 0
- syndrome_valid  output  1  1-cycle pulse when parity_ok updates

Behaviour:
- Clocking and reset: clk is the only clock. Reset is synchronous, active-high; only the polarity and synchronicity are fixed.
- Reset values: state=ACCUM, in_cnt=0, out_cnt=0, out_valid=0, out_last=0, out_data=0, parity_ok=0, syndrome_valid=0, min1=min2=15, min_idx=0, sign_acc=0, hd_acc=0, sign store=0.
- Reset mid-frame discards the partial frame. No output handshake occurs in the reset cycle.
- Enable: when en=0, in_ready=0 and out_valid=0; all registers and the state hold; syndrome_valid=0.
- ACCUM state:
  - in_ready=1 (en=1). A transfer occurs on in_valid & in_ready.
  - Per accepted message at index k=in_cnt: store sign[k]; sign_acc ^= sign; hd_acc ^= hd.
  - Magnitude update: if mag < min1 then min2<=min1, min1<=mag, min_idx<=k. Else if mag < min2 then min2<=mag.
  - Ties: equal to min1 goes to min2, so min_idx is the first occurrence.
  - in_cnt increments. On accepting k=DC-1:
    - state<=EMIT, in_cnt<=0.
    - parity_ok<=~(hd_acc^hd), syndrome_valid<=1 for one cycle.
    - Final min1/min2/min_idx/sign_acc are latched into the output bank.
- EMIT state:
  - in_ready=0, out_valid=1 (en=1). For edge j=out_cnt:
    - sign = sign_acc ^ sign[j].
    - mag = (j==min_idx) ? min2 : min1.
    - out_last = (j==DC-1).
  - out_data, out_valid and out_last are registered and change only on a handshake or state change.
  - out_data is stable while out_valid & ~out_ready.
  - On out_valid & out_ready: out_cnt++. At j=DC-1: out_cnt<=0, state<=ACCUM, min1/min2<=15, accumulators cleared.
  - The first input of the next frame is accepted the cycle after the last output handshake.
- Latency: first out_valid is asserted in the cycle after the last input is accepted.
- Throughput: 2·DC cycles per frame when there is no backpressure.
- in_data[5] (hd) affects only the parity outputs, never the messages.
- in_cnt, out_cnt and min_idx are $clog2(DC) bits wide. Magnitudes are 4-bit unsigned; no arithmetic widening is needed.

Optional Feature:
- OFFSET_MINSUM_EN defined: the emitted magnitude is max(mag-OFFSET, 0), saturating at 0. The subtraction is applied at output selection; the stored minima are unchanged.
- Not defined: plain min-sum; OFFSET is ignored.

Test Plan:
- Basic frame: DC=6; mags 5,3,7,3,9,2; signs 1,0,0,1,0,0; hd 0,0,1,0,0,0.
  - out_data = 12,02,02,12,02,03 (hex), out_last on the 6th.
  - parity_ok=0; syndrome_valid pulses once.
- Ties: all mags 4, signs 1,1,1,1,1,0.
  - All out mags 4; signs 0,0,0,0,0,1 → out_data 04,04,04,04,04,14.
  - hd all 0 → parity_ok=1.
- Backpressure: hold out_ready=0 for 5 cycles at edge 2; out_data stays at edge-2 value; no edge skipped or duplicated. Also toggle in_valid with gaps during ACCUM; minima are still correct.
- Enable/reset: deassert en mid-ACCUM for 3 cycles → in_ready=0 and the frame resumes correctly. Assert rst after 3 inputs → the next 6 inputs form a clean frame with no stale minima.
- Offset (macro defined, OFFSET=1): basic-frame stimulus → out_data 11,01,01,11,01,02. A frame containing mag 0 → emitted mags clamp at 0.
